// File: rtl/mac_stream_interface.sv
// mac_stream_interface
//
// Byte-serial front end for the MAC peripheral. Collects operand A and then
// operand B as BUS_W-wide beats over a valid/ready handshake, hands the
// assembled operands to the MAC core with a one-cycle start pulse, waits a
// fixed MAC latency, then streams the ACC_W-bit result back LSB-first over a
// second valid/ready handshake. Only one frame is in flight at a time.
//
// Parameters
//   BUS_W   beat width in bits
//   OP_W    operand width (multiple of BUS_W), NA = OP_W/BUS_W beats each
//   ACC_W   result width (multiple of BUS_W), NR = ACC_W/BUS_W output beats
//   MAC_LAT cycles from mac_start to a valid mac_result (>= 1)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    input beat handshake and payload
//   in_first                     marks beat 0 of a frame (resync)
//   clear_and_mult_in            MAC control, sampled on beat 0
//   signed_mode                  signed flag, sampled on beat 0
//   out_valid/out_ready/out_data result beat handshake and payload
//   out_last                     high on the final result beat
//   out_overflow                 captured MAC overflow flag
//   mac_data_a, mac_data_b       assembled operands to the MAC core
//   mac_clear_and_mult           captured control to the MAC core
//   mac_signed_mode              captured signed flag to the MAC core
//   mac_start                    one-cycle start pulse to the MAC core
//   mac_result, mac_overflow     result and overflow from the MAC core
//   sync_error                   one-cycle pulse when a partial frame is dropped

module mac_stream_interface #(
  parameter int BUS_W   = 8,
  parameter int OP_W    = 8,
  parameter int ACC_W   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_first,
  input  logic             clear_and_mult_in,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic             out_overflow,
  output logic [OP_W-1:0]  mac_data_a,
  output logic [OP_W-1:0]  mac_data_b,
  output logic             mac_clear_and_mult,
  output logic             mac_signed_mode,
  output logic             mac_start,
  input  logic [ACC_W-1:0] mac_result,
  input  logic             mac_overflow,
  output logic             sync_error
);

  localparam int NA    = OP_W / BUS_W;
  localparam int NR    = ACC_W / BUS_W;
  localparam int BEATS = 2 * NA;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OUT_W = (NR > 1) ? $clog2(NR) : 1;
  localparam int LAT_W = $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WAIT    = 2'd1,
    S_SEND    = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    beat_cnt;
  logic [CNT_W-1:0]    wr_idx;
  logic [OUT_W-1:0]    out_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [2*OP_W-1:0]   frame_buf;
  logic [2*OP_W-1:0]   frame_next;
  logic                ctrl_clear;
  logic                ctrl_signed;
  logic [ACC_W-1:0]    result_reg;
  logic                ovf_reg;

  logic in_accept;
  logic resync;
  logic last_beat;
  logic out_hs;
  logic out_final;
  logic lat_done;

  // Handshake qualifiers shared by the FSM and the datapath. A beat flagged
  // in_first while a frame is partly collected restarts the frame; it can
  // never be the last beat because it becomes beat 0.
  assign in_accept = in_valid && in_ready;
  assign resync    = in_accept && in_first && (beat_cnt != '0);
  assign last_beat = in_accept && !resync && (beat_cnt == CNT_W'(BEATS - 1));
  assign out_hs    = out_valid && out_ready;
  assign out_final = (out_cnt == OUT_W'(NR - 1));
  assign lat_done  = (lat_cnt == LAT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: collect beats, wait out the MAC latency, send result.
  always_comb begin
    state_next = state;
    case (state)
      S_COLLECT: if (last_beat)           state_next = S_WAIT;
      S_WAIT:    if (lat_done)            state_next = S_SEND;
      S_SEND:    if (out_hs && out_final) state_next = S_COLLECT;
      default:                            state_next = S_COLLECT;
    endcase
  end

  // Handshake outputs decoded purely from state so that reset drops them
  // immediately without waiting for a clock edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      S_COLLECT: in_ready = 1'b1;
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = out_final;
      end
      default: ;
    endcase
  end

  // Frame buffer with the incoming beat merged in. The completing beat is
  // taken from here so the mac_* registers load in the same edge that
  // accepts it.
  always_comb begin
    frame_next = frame_buf;
    wr_idx     = resync ? '0 : beat_cnt;
    frame_next[BUS_W*wr_idx +: BUS_W] = in_data;
  end

  // Input side: beat counter, frame buffer and beat-0 control capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt    <= '0;
      frame_buf   <= '0;
      ctrl_clear  <= 1'b0;
      ctrl_signed <= 1'b0;
    end else if (in_accept) begin
      frame_buf <= frame_next;
      if (resync) begin
        beat_cnt <= CNT_W'(1);
      end else if (last_beat) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (resync || beat_cnt == '0) begin
        ctrl_clear  <= clear_and_mult_in;
        ctrl_signed <= signed_mode;
      end
    end
  end

  // Held operand/control registers towards the MAC core plus the start and
  // sync-error pulses. The held values only change when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_data_a         <= '0;
      mac_data_b         <= '0;
      mac_clear_and_mult <= 1'b0;
      mac_signed_mode    <= 1'b0;
      mac_start          <= 1'b0;
      sync_error         <= 1'b0;
    end else begin
      mac_start  <= last_beat;
      sync_error <= resync;
      if (last_beat) begin
        mac_data_a         <= frame_next[OP_W-1:0];
        mac_data_b         <= frame_next[2*OP_W-1:OP_W];
        mac_clear_and_mult <= ctrl_clear;
        mac_signed_mode    <= ctrl_signed;
      end
    end
  end

  // Latency counter and result capture. The counter loads MAC_LAT with the
  // last input beat; the result is sampled on the edge where it would reach
  // zero, which is the end of cycle (mac_start + MAC_LAT - 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (last_beat) begin
        lat_cnt <= LAT_W'(MAC_LAT);
      end else if (state == S_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (state == S_WAIT && lat_done) begin
        result_reg <= mac_result;
        ovf_reg    <= mac_overflow;
      end
    end
  end

  // Output beat counter; advances only on a completed output handshake so
  // the presented slice stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (out_hs) begin
      out_cnt <= out_final ? '0 : out_cnt + OUT_W'(1);
    end
  end

  assign out_data     = result_reg[BUS_W*out_cnt +: BUS_W];
  assign out_overflow = ovf_reg;

endmodule

// File: tb/tb_mac_stream_interface.sv
// tb_mac_stream_interface
//
// Directed bench for mac_stream_interface. A default instance (8/8/16,
// latency 1) and a wide instance (8/16/32, latency 3) share the clock and
// reset. Each has a behavioural MAC core computing A*B from the held
// operands. Inputs are driven and outputs sampled on the falling edge.

module tb_mac_stream_interface;

  logic clk;
  logic rst_n;

  // Default instance signals.
  logic        in_valid, in_ready, in_first, clear_in, signed_in;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last, out_overflow;
  logic [7:0]  out_data;
  logic [7:0]  mac_a, mac_b;
  logic        mac_clear, mac_signed, mac_start;
  logic [15:0] mac_result;
  logic        mac_ovf, sync_error;

  // Wide instance signals.
  logic        w_in_valid, w_in_ready, w_in_first;
  logic [7:0]  w_in_data;
  logic        w_out_valid, w_out_ready, w_out_last, w_out_overflow;
  logic [7:0]  w_out_data;
  logic [15:0] w_mac_a, w_mac_b;
  logic        w_mac_clear, w_mac_signed, w_mac_start;
  logic [31:0] w_mac_result;
  logic        w_sync_error;

  int checks = 0;
  int errors = 0;

  // Behavioural MAC cores: plain unsigned products of the held operands.
  assign mac_result   = 16'(mac_a) * 16'(mac_b);
  assign w_mac_result = 32'(w_mac_a) * 32'(w_mac_b);

  mac_stream_interface dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .clear_and_mult_in(clear_in), .signed_mode(signed_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_overflow(out_overflow),
    .mac_data_a(mac_a), .mac_data_b(mac_b),
    .mac_clear_and_mult(mac_clear), .mac_signed_mode(mac_signed),
    .mac_start(mac_start), .mac_result(mac_result),
    .mac_overflow(mac_ovf), .sync_error(sync_error)
  );

  mac_stream_interface #(.BUS_W(8), .OP_W(16), .ACC_W(32), .MAC_LAT(3)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_first(w_in_first), .clear_and_mult_in(1'b0), .signed_mode(1'b0),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_last(w_out_last), .out_overflow(w_out_overflow),
    .mac_data_a(w_mac_a), .mac_data_b(w_mac_b),
    .mac_clear_and_mult(w_mac_clear), .mac_signed_mode(w_mac_signed),
    .mac_start(w_mac_start), .mac_result(w_mac_result),
    .mac_overflow(1'b0), .sync_error(w_sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and counts and reports it when it fails.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives the default instance's input beat.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic first, input logic clr,
                               input logic sgn);
    in_valid  = v;
    in_data   = d;
    in_first  = first;
    clear_in  = clr;
    signed_in = sgn;
  endtask

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready   = 1'($urandom_range(0, 1));
      mac_ovf     = 1'($urandom_range(0, 1));
      w_in_valid  = 1'($urandom_range(0, 1));
      w_in_data   = 8'($urandom);
      w_in_first  = 1'($urandom_range(0, 1));
      w_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checkOutput("rst in_ready", in_ready, 1);
    checkOutput("rst out_valid", out_valid, 0);
    checkOutput("rst out_last", out_last, 0);
    checkOutput("rst out_overflow", out_overflow, 0);
    checkOutput("rst out_data", out_data, 0);
    checkOutput("rst mac_start", mac_start, 0);
    checkOutput("rst sync_error", sync_error, 0);
    checkOutput("rst mac_a", mac_a, 0);
    checkOutput("rst mac_b", mac_b, 0);
    checkOutput("rst mac_clear", mac_clear, 0);
    checkOutput("rst mac_signed", mac_signed, 0);
    checkOutput("rst wide in_ready", w_in_ready, 1);
    checkOutput("rst wide out_valid", w_out_valid, 0);

    // Basic frame with backpressure and overflow capture.
    w_in_valid = 1'b0; w_in_data = 8'h00; w_in_first = 1'b0; w_out_ready = 1'b1;
    out_ready = 1'b0;
    mac_ovf   = 1'b1;
    rst_n     = 1'b1;
    applyStimulus(1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("basic in_ready beat1", in_ready, 1);
    checkOutput("basic mac_start early", mac_start, 0);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("basic mac_start", mac_start, 1);
    checkOutput("basic mac_a", mac_a, 8'h03);
    checkOutput("basic mac_b", mac_b, 8'h05);
    checkOutput("basic mac_clear", mac_clear, 1);
    checkOutput("basic mac_signed", mac_signed, 0);
    checkOutput("basic in_ready wait", in_ready, 0);
    checkOutput("basic out_valid wait", out_valid, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp out_valid", out_valid, 1);
      checkOutput("bp out_data beat0", out_data, 8'h0F);
      checkOutput("bp out_last beat0", out_last, 0);
      checkOutput("bp in_ready", in_ready, 0);
      checkOutput("bp out_overflow", out_overflow, 1);
      checkOutput("bp mac_start low", mac_start, 0);
    end
    out_ready = 1'b1;
    mac_ovf   = 1'b0;
    @(negedge clk);
    checkOutput("basic out_data beat1", out_data, 8'h00);
    checkOutput("basic out_last beat1", out_last, 1);
    checkOutput("basic out_valid beat1", out_valid, 1);
    @(negedge clk);
    checkOutput("basic out_valid done", out_valid, 0);
    checkOutput("basic in_ready back", in_ready, 1);
    checkOutput("basic mac_a held", mac_a, 8'h03);

    // Resync: a second in_first restarts the frame.
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("resync sync_error", sync_error, 1);
    checkOutput("resync mac_start none", mac_start, 0);
    checkOutput("resync mac_a held", mac_a, 8'h03);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("resync sync_error once", sync_error, 0);
    checkOutput("resync mac_start", mac_start, 1);
    checkOutput("resync mac_a", mac_a, 8'h22);
    checkOutput("resync mac_b", mac_b, 8'h33);
    checkOutput("resync mac_clear", mac_clear, 1);
    checkOutput("resync mac_signed", mac_signed, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("resync out_data beat0", out_data, 8'hC6);
    checkOutput("resync out_last beat0", out_last, 0);
    checkOutput("resync out_overflow", out_overflow, 0);
    @(negedge clk);
    checkOutput("resync out_data beat1", out_data, 8'h06);
    checkOutput("resync out_last beat1", out_last, 1);
    @(negedge clk);
    checkOutput("resync out_valid done", out_valid, 0);

    // Wide configuration with an input stall mid-frame.
    w_in_valid = 1'b1; w_in_data = 8'h34; w_in_first = 1'b1;
    @(negedge clk);
    w_in_data = 8'h12; w_in_first = 1'b0;
    @(negedge clk);
    w_in_valid = 1'b0; w_in_data = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("wide stall in_ready", w_in_ready, 1);
      checkOutput("wide stall mac_start", w_mac_start, 0);
      checkOutput("wide stall mac_a held", w_mac_a, 16'h0000);
    end
    w_in_valid = 1'b1; w_in_data = 8'h78;
    @(negedge clk);
    w_in_data = 8'h56;
    @(negedge clk);
    checkOutput("wide mac_start", w_mac_start, 1);
    checkOutput("wide mac_a", w_mac_a, 16'h1234);
    checkOutput("wide mac_b", w_mac_b, 16'h5678);
    checkOutput("wide sync_error", w_sync_error, 0);
    w_in_valid = 1'b0;
    @(negedge clk);
    checkOutput("wide out_valid T+1", w_out_valid, 0);
    @(negedge clk);
    checkOutput("wide out_valid T+2", w_out_valid, 0);
    @(negedge clk);
    checkOutput("wide out_valid T+3", w_out_valid, 1);
    checkOutput("wide beat0", w_out_data, 8'h60);
    checkOutput("wide last0", w_out_last, 0);
    @(negedge clk);
    checkOutput("wide beat1", w_out_data, 8'h00);
    checkOutput("wide last1", w_out_last, 0);
    @(negedge clk);
    checkOutput("wide beat2", w_out_data, 8'h26);
    checkOutput("wide last2", w_out_last, 0);
    @(negedge clk);
    checkOutput("wide beat3", w_out_data, 8'h06);
    checkOutput("wide last3", w_out_last, 1);
    @(negedge clk);
    checkOutput("wide out_valid done", w_out_valid, 0);
    checkOutput("wide in_ready back", w_in_ready, 1);

    // Reset asserted during output beat 1.
    applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst mac_a", mac_a, 8'h07);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midrst beat0", out_data, 8'h3F);
    @(negedge clk);
    checkOutput("midrst beat1 last", out_last, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid drop", out_valid, 0);
    checkOutput("midrst out_last drop", out_last, 0);
    checkOutput("midrst in_ready", in_ready, 1);
    checkOutput("midrst mac_a cleared", mac_a, 0);
    checkOutput("midrst out_data cleared", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postrst out_valid", out_valid, 0);
      checkOutput("postrst in_ready", in_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
